// File: rtl/vdp_port_ctrl.sv
// Z80 I/O front end for the VDP: ports 0xBE/0xBF drive VRAM, register, status and (with VDP_CRAM_EN) colour RAM.
// Events act 3 cycles after the strobe edge; a busy FSM parks one event in a pending slot, later ones are dropped.
module vdp_port_ctrl (
    input  logic        clk_100,
    input  logic        rst_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic [7:0]  addr_bus,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        BUSY,
    output logic        vram_req,
    output logic        vram_we,
    output logic [13:0] vram_addr,
    output logic [7:0]  vram_wdata,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic        cram_we,
    output logic [4:0]  cram_addr,
    output logic [7:0]  cram_wdata,
    output logic        reg_we,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  status_in,
    output logic        status_rd
);

    typedef enum logic [1:0] {IDLE = 2'd0, VWR = 2'd1, VRD = 2'd2} state_t;

    typedef struct packed {
        logic       is_wr;
        logic       is_ctrl;
        logic [7:0] dat;
    } ev_t;

    logic [1:0]  iorq_sync, rd_sync, wr_sync;
    logic        wr_act, rd_act, wr_act_d, rd_act_d;
    logic        wr_rise, rd_rise, port_hit, ev_vld;
    ev_t         new_ev, pend_ev, exec_ev;
    logic        pend_vld, rd_wait, ready, exec_vld, store, cram_fire;

    state_t      state;
    logic        first_byte;
    logic [1:0]  code;
    logic [13:0] addr, addr_inc, ctrl_addr;
    logic [7:0]  read_buf;

    always_ff @(posedge clk_100 or negedge rst_L) begin
        if (!rst_L) begin
            iorq_sync <= 2'b11;
            rd_sync   <= 2'b11;
            wr_sync   <= 2'b11;
            wr_act_d  <= 1'b0;
            rd_act_d  <= 1'b0;
        end else begin
            iorq_sync <= {iorq_sync[0], IORQ_L};
            rd_sync   <= {rd_sync[0], RD_L};
            wr_sync   <= {wr_sync[0], WR_L};
            wr_act_d  <= wr_act;
            rd_act_d  <= rd_act;
        end
    end

    assign wr_act   = ~iorq_sync[1] & ~wr_sync[1];
    assign rd_act   = ~iorq_sync[1] & ~rd_sync[1];
    assign wr_rise  = wr_act & ~wr_act_d;
    assign rd_rise  = rd_act & ~rd_act_d;
    assign port_hit = (addr_bus[7:6] == 2'b10);
    assign ev_vld   = port_hit & (wr_rise | rd_rise);
    assign new_ev   = {wr_rise, addr_bus[0], data_in};

    // A data read defers its prefetch until the strobe is gone, so nothing else may run meanwhile.
    assign ready     = (state == IDLE) & ~rd_wait;
    assign exec_vld  = ready & (pend_vld | ev_vld);
    assign exec_ev   = pend_vld ? pend_ev : new_ev;
    assign store     = ev_vld & (ready ? pend_vld : ~pend_vld);
    assign addr_inc  = addr + 14'd1;
    assign ctrl_addr = {exec_ev.dat[5:0], addr[7:0]};

`ifdef VDP_CRAM_EN
    assign cram_fire = exec_vld & exec_ev.is_wr & ~exec_ev.is_ctrl & (code == 2'd3);

    always_ff @(posedge clk_100 or negedge rst_L) begin
        if (!rst_L) begin
            cram_we    <= 1'b0;
            cram_addr  <= 5'd0;
            cram_wdata <= 8'd0;
        end else begin
            cram_we <= cram_fire;
            if (cram_fire) begin
                cram_addr  <= addr[4:0];
                cram_wdata <= exec_ev.dat;
            end
        end
    end
`else
    assign cram_fire  = 1'b0;
    assign cram_we    = 1'b0;
    assign cram_addr  = 5'd0;
    assign cram_wdata = 8'd0;
`endif

    always_ff @(posedge clk_100 or negedge rst_L) begin
        if (!rst_L) begin
            state      <= IDLE;
            first_byte <= 1'b1;
            code       <= 2'd0;
            addr       <= 14'd0;
            read_buf   <= 8'd0;
            pend_vld   <= 1'b0;
            pend_ev    <= '0;
            rd_wait    <= 1'b0;
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= 14'd0;
            vram_wdata <= 8'd0;
            reg_we     <= 1'b0;
            reg_addr   <= 4'd0;
            reg_wdata  <= 8'd0;
            status_rd  <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            status_rd <= 1'b0;

            if (store) begin
                pend_vld <= 1'b1;
                pend_ev  <= new_ev;
            end else if (exec_vld && pend_vld) begin
                pend_vld <= 1'b0;
            end

            case (state)
                VWR: begin
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                VRD: begin
                    if (vram_ack) begin
                        vram_req <= 1'b0;
                        read_buf <= vram_rdata;
                        state    <= IDLE;
                    end
                end
                default: begin
                    if (exec_vld) begin
                        if (exec_ev.is_wr && exec_ev.is_ctrl) begin
                            if (first_byte) begin
                                addr[7:0]  <= exec_ev.dat;
                                first_byte <= 1'b0;
                            end else begin
                                code       <= exec_ev.dat[7:6];
                                first_byte <= 1'b1;
                                if (exec_ev.dat[7:6] == 2'd0) begin
                                    state     <= VRD;
                                    vram_req  <= 1'b1;
                                    vram_we   <= 1'b0;
                                    vram_addr <= ctrl_addr;
                                    addr      <= ctrl_addr + 14'd1;
                                end else begin
                                    addr <= ctrl_addr;
                                    if (exec_ev.dat[7:6] == 2'd2) begin
                                        reg_we    <= 1'b1;
                                        reg_addr  <= exec_ev.dat[3:0];
                                        reg_wdata <= addr[7:0];
                                    end
                                end
                            end
                        end else if (exec_ev.is_wr) begin
                            first_byte <= 1'b1;
                            addr       <= addr_inc;
                            if (!cram_fire) begin
                                state      <= VWR;
                                vram_req   <= 1'b1;
                                vram_we    <= 1'b1;
                                vram_addr  <= addr;
                                vram_wdata <= exec_ev.dat;
                                read_buf   <= exec_ev.dat;
                            end
                        end else if (exec_ev.is_ctrl) begin
                            first_byte <= 1'b1;
                            status_rd  <= 1'b1;
                        end else begin
                            first_byte <= 1'b1;
                            rd_wait    <= 1'b1;
                        end
                    end else if (rd_wait && !rd_act) begin
                        rd_wait   <= 1'b0;
                        state     <= VRD;
                        vram_req  <= 1'b1;
                        vram_we   <= 1'b0;
                        vram_addr <= addr;
                        addr      <= addr_inc;
                    end
                end
            endcase
        end
    end

    assign BUSY     = (state != IDLE) | pend_vld;
    assign data_oe  = rd_act & port_hit;
    assign data_out = data_oe ? (addr_bus[0] ? status_in : read_buf) : 8'h00;

endmodule
